// File: rtl/cmplx_mult_pipe.sv
// rtl/cmplx_mult_pipe.sv - pipelined signed Q-format complex multiplier, 3-cycle latency
// Stage 1 products, stage 2 re/im sums, stage 3 rounding and range check.
module cmplx_mult_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_re,
    input  logic [DATA_WIDTH-1:0] a_im,
    input  logic [DATA_WIDTH-1:0] b_re,
    input  logic [DATA_WIDTH-1:0] b_im,
    input  logic [1:0]            rnd_mode,
    input  logic                  sat_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] p_re,
    output logic [DATA_WIDTH-1:0] p_im,
    output logic                  ovf
);

    localparam int W   = DATA_WIDTH;
    localparam int PW  = 2 * W;
    localparam int SW  = 2 * W + 1;
    localparam int EW  = 2 * W + 2;
    localparam int HSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

    localparam logic signed [EW-1:0] TRUNC_ADD = (EW'(1) << FRAC_BITS) - EW'(1);
    localparam logic signed [EW-1:0] HALF_ADD  = (FRAC_BITS > 0) ? (EW'(1) << HSH) : '0;
    localparam logic signed [EW-1:0] MAXV      = {{(EW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [EW-1:0] MINV      = {{(EW - W + 1){1'b1}}, {(W - 1){1'b0}}};

    // Returns {overflow, result} for one scaled component.
    function automatic logic [W:0] scale_one(input logic signed [SW-1:0] v,
                                             input logic [1:0] mode,
                                             input logic sat);
        logic signed [EW-1:0] ext;
        logic signed [EW-1:0] add;
        logic signed [EW-1:0] sum;
        logic signed [EW-1:0] sh;
        logic                 hi;
        logic                 lo;
        logic [W-1:0]         res;
        ext = {v[SW-1], v};
        case (mode)
            2'b00:   add = '0;
            2'b01:   add = ext[EW-1] ? TRUNC_ADD : '0;
            default: add = HALF_ADD;
        endcase
        sum = ext + add;
        sh  = sum >>> FRAC_BITS;
        hi  = (sh > MAXV);
        lo  = (sh < MINV);
        if (sat && hi) begin
            res = MAXV[W-1:0];
        end else if (sat && lo) begin
            res = MINV[W-1:0];
        end else begin
            res = sh[W-1:0];
        end
        return {hi | lo, res};
    endfunction

    logic                 stall;

    logic                 v1_q, v1_d;
    logic [1:0]           rnd1_q, rnd1_d;
    logic                 sat1_q, sat1_d;
    logic signed [PW-1:0] prod_rr_q, prod_rr_d;
    logic signed [PW-1:0] prod_ii_q, prod_ii_d;
    logic signed [PW-1:0] prod_ri_q, prod_ri_d;
    logic signed [PW-1:0] prod_ir_q, prod_ir_d;

    logic                 v2_q, v2_d;
    logic [1:0]           rnd2_q, rnd2_d;
    logic                 sat2_q, sat2_d;
    logic signed [SW-1:0] re2_q, re2_d;
    logic signed [SW-1:0] im2_q, im2_d;

    logic                 v3_q, v3_d;
    logic [W-1:0]         p_re_q, p_re_d;
    logic [W-1:0]         p_im_q, p_im_d;
    logic                 ovf_q, ovf_d;

    logic [W:0]           sc_re;
    logic [W:0]           sc_im;

    always_comb begin
        stall = v3_q && !out_ready;
        sc_re = scale_one(re2_q, rnd2_q, sat2_q);
        sc_im = scale_one(im2_q, rnd2_q, sat2_q);

        v1_d      = v1_q;
        rnd1_d    = rnd1_q;
        sat1_d    = sat1_q;
        prod_rr_d = prod_rr_q;
        prod_ii_d = prod_ii_q;
        prod_ri_d = prod_ri_q;
        prod_ir_d = prod_ir_q;
        v2_d      = v2_q;
        rnd2_d    = rnd2_q;
        sat2_d    = sat2_q;
        re2_d     = re2_q;
        im2_d     = im2_q;
        v3_d      = v3_q;
        p_re_d    = p_re_q;
        p_im_d    = p_im_q;
        ovf_d     = ovf_q;

        if (!stall) begin
            v1_d      = in_valid;
            rnd1_d    = rnd_mode;
            sat1_d    = sat_en;
            prod_rr_d = PW'($signed(a_re)) * PW'($signed(b_re));
            prod_ii_d = PW'($signed(a_im)) * PW'($signed(b_im));
            prod_ri_d = PW'($signed(a_re)) * PW'($signed(b_im));
            prod_ir_d = PW'($signed(a_im)) * PW'($signed(b_re));

            v2_d   = v1_q;
            rnd2_d = rnd1_q;
            sat2_d = sat1_q;
            re2_d  = SW'(prod_rr_q) - SW'(prod_ii_q);
            im2_d  = SW'(prod_ri_q) + SW'(prod_ir_q);

            v3_d   = v2_q;
            p_re_d = sc_re[W-1:0];
            p_im_d = sc_im[W-1:0];
            ovf_d  = v2_q && (sc_re[W] || sc_im[W]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            rnd1_q    <= '0;
            sat1_q    <= 1'b0;
            prod_rr_q <= '0;
            prod_ii_q <= '0;
            prod_ri_q <= '0;
            prod_ir_q <= '0;
            v2_q      <= 1'b0;
            rnd2_q    <= '0;
            sat2_q    <= 1'b0;
            re2_q     <= '0;
            im2_q     <= '0;
            v3_q      <= 1'b0;
            p_re_q    <= '0;
            p_im_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            rnd1_q    <= rnd1_d;
            sat1_q    <= sat1_d;
            prod_rr_q <= prod_rr_d;
            prod_ii_q <= prod_ii_d;
            prod_ri_q <= prod_ri_d;
            prod_ir_q <= prod_ir_d;
            v2_q      <= v2_d;
            rnd2_q    <= rnd2_d;
            sat2_q    <= sat2_d;
            re2_q     <= re2_d;
            im2_q     <= im2_d;
            v3_q      <= v3_d;
            p_re_q    <= p_re_d;
            p_im_q    <= p_im_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        in_ready  = !stall;
        out_valid = v3_q;
        p_re      = p_re_q;
        p_im      = p_im_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// tb/tb_cmplx_mult_pipe.sv - directed vector bench for cmplx_mult_pipe (W=16, Q8)
module tb_cmplx_mult_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic [1:0]   rnd_mode = 2'b00;
    logic         sat_en = 1'b1;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] p_re, p_im;
    logic         ovf;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [W-1:0] a_re, a_im, b_re, b_im;
        logic [1:0]   rnd;
        logic         sat;
        logic [W-1:0] e_re, e_im;
        logic         e_ovf;
    } vec_t;

    vec_t vecs[10];

    cmplx_mult_pipe #(.DATA_WIDTH(W), .FRAC_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .rnd_mode(rnd_mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .p_re(p_re), .p_im(p_im), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        a_re = v.a_re; a_im = v.a_im; b_re = v.b_re; b_im = v.b_im;
        rnd_mode = v.rnd; sat_en = v.sat; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " p_re"}, 32'(p_re), 32'(v.e_re));
        check({tag, " p_im"}, 32'(p_im), 32'(v.e_im));
        check({tag, " ovf"}, 32'(ovf), 32'(v.e_ovf));
    endtask

    initial begin
        int got;
        int stall_seen;
        int extra;

        vecs[0] = '{16'h0180, 16'h0000, 16'h0200, 16'h0000, 2'b00, 1'b1, 16'h0300, 16'h0000, 1'b0};
        vecs[1] = '{16'h0000, 16'h0100, 16'h0000, 16'h0100, 2'b00, 1'b1, 16'hFF00, 16'h0000, 1'b0};
        vecs[2] = '{16'h0100, 16'h0100, 16'h0100, 16'hFF00, 2'b00, 1'b1, 16'h0200, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 2'b00, 1'b1, 16'hFFFF, 16'h0000, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 2'b01, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 2'b10, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[6] = '{16'h0001, 16'h0000, 16'h0080, 16'h0000, 2'b10, 1'b1, 16'h0001, 16'h0000, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 2'b00, 1'b1, 16'h7FFF, 16'h0000, 1'b1};
        vecs[8] = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 2'b00, 1'b0, 16'hFF00, 16'h0000, 1'b1};
        vecs[9] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 2'b00, 1'b1, 16'h0000, 16'h7FFF, 1'b1};

        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset p_re", 32'(p_re), 32'd0);
        check("reset p_im", 32'(p_im), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: six samples, out_ready low for four cycles mid-stream.
        got = 0;
        stall_seen = 0;
        fork
            begin
                int i = 0;
                int guard = 0;
                while (i < 6 && guard < 40) begin
                    @(negedge clk);
                    a_re = 16'hFFFF; a_im = 16'((i + 1) * 16'h0100);
                    b_re = 16'h0080; b_im = 16'h0000;
                    rnd_mode = (i % 2 == 0) ? 2'b00 : 2'b01;
                    sat_en = 1'b1; in_valid = 1'b1;
                    #2;
                    if (in_ready) i++;
                    guard++;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40 && got < 6; c++) begin
                    @(negedge clk);
                    out_ready = !(c >= 5 && c <= 8);
                    #1;
                    if (out_valid) begin
                        check($sformatf("bp%0d p_re", got), 32'(p_re),
                              (got % 2 == 0) ? 32'hFFFF : 32'h0000);
                        check($sformatf("bp%0d p_im", got), 32'(p_im), 32'((got + 1) * 16'h0080));
                        if (out_ready) begin
                            got++;
                        end else begin
                            stall_seen++;
                            check("bp in_ready stalled", 32'(in_ready), 32'd0);
                        end
                    end
                end
            end
        join
        out_ready = 1'b1;
        check("bp samples received", 32'(got), 32'd6);
        check("bp stall cycles", 32'(stall_seen), 32'd4);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        check("bp no duplicates", 32'(extra), 32'd0);

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_re = vecs[i].a_re; a_im = vecs[i].a_im; b_re = vecs[i].b_re; b_im = vecs[i].b_im;
            rnd_mode = 2'b00; sat_en = 1'b1; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst p_re", 32'(p_re), 32'd0);
        check("async rst p_im", 32'(p_im), 32'd0);
        check("async rst ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        check("post-reset stale valid", 32'(extra), 32'd0);
        run_vec(vecs[0], "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cmplx_mult_pipe.md
Name: cmplx_mult_pipe

Overview:
Pipelined signed fixed-point complex multiplier for the FFT butterfly datapath (twiddle × data).
- Generalises the scalar Q-format multiplier: parametrised width and fraction bits, selectable rounding, optional saturation with overflow flag, valid/ready flow control.
- Fixed 3-cycle latency when not stalled.
- Sits between the data/twiddle fetch stage and the butterfly adder.

Parameters:
DATA_WIDTH, 32, bit width of each real/imag component (two's complement, signed).
FRAC_BITS, 16, fractional bits of the Q format; legal range 0..DATA_WIDTH-1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  input sample valid
in_ready  output  1  block accepts input this cycle
a_re, a_im  input  DATA_WIDTH  operand A (data)
b_re, b_im  input  DATA_WIDTH  operand B (twiddle)
rnd_mode  input  2  00 floor, 01 truncate toward zero, 10/11 round half up
sat_en  input  1  1 = saturate on overflow, 0 = wrap
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
p_re, p_im  output  DATA_WIDTH  product components, same Q format
ovf  output  1  this result overflowed DATA_WIDTH (re or im)

Behaviour:
- Reset (rst low, async): all pipeline registers cleared; out_valid=0, p_re=p_im=0, ovf=0. in_ready is 1 out of reset.
- Handshake: a transfer occurs when valid && ready on either side.
  - stall = out_valid && !out_ready; in_ready = !stall (combinational).
  - When stall is 1, all three stages hold their contents.
  - When stall is 0, all stages advance; bubbles (valid=0) propagate.
  - Data, rnd_mode and sat_en are captured together at input transfer and travel with the sample. Mode changes never affect in-flight samples.
  - Outputs hold stable while out_valid && !out_ready.
- Stage 1: register four signed products ar*br, ai*bi, ar*bi, ai*br, each 2*DATA_WIDTH bits.
- Stage 2: register re = ar*br - ai*bi and im = ar*bi + ai*br, each 2*DATA_WIDTH+1 bits; no overflow possible.
- Stage 3: scale by 2^-FRAC_BITS, then range-check.
  - Floor: arithmetic shift right.
  - Truncate toward zero: add (2^FRAC_BITS - 1) before the shift when the value is negative.
  - Half up: add 2^(FRAC_BITS-1) before the shift.
  - With FRAC_BITS=0 all modes are identical.
  - Overflow: the scaled value is outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] for re or im.
  - sat_en=1: clamp to the nearest bound. sat_en=0: keep the low DATA_WIDTH bits.
  - ovf is asserted for that sample in either mode.
- Latency: a sample accepted in cycle N appears with out_valid=1 in cycle N+3 if there is no stall; each stall cycle adds one. Full throughput is 1 sample/cycle.
- Corner operand: -2^(DATA_WIDTH-1) in any operand is legal. The full-width products are exact, so there is no special case.
- Reset mid-operation flushes all in-flight samples; none emerge after reset release.

Test Plan (DATA_WIDTH=16, FRAC_BITS=8 unless stated):
1. Basic real product: a=(0x0180,0), b=(0x0200,0), rnd=00, sat=1 -> p=(0x0300,0x0000), ovf=0, out_valid exactly 3 cycles after acceptance.
2. Complex j*j: a=(0,0x0100), b=(0,0x0100) -> p=(0xFF00,0x0000). Then a=(0x0100,0x0100), b=(0x0100,0xFF00) -> p=(0x0200,0x0000).
3. Rounding modes: a=(0xFFFF,0), b=(0x0080,0) -> p_re=0xFFFF for rnd=00; 0x0000 for rnd=01; 0x0000 for rnd=10. Also a=(0x0001,0), b=(0x0080,0), rnd=10 -> p_re=0x0001.
4. Overflow: a=(0x7FFF,0), b=(0x7FFF,0): sat=1 -> p_re=0x7FFF, ovf=1; sat=0 -> p_re=0xFF00, ovf=1. Also a=(0x8000,0x8000), b=(0x8000,0x8000) -> im saturates to 0x7FFF.
5. Backpressure: stream 6 distinct samples back-to-back with out_ready low for 4 cycles mid-stream -> in_ready drops while stalled, no sample lost or duplicated, outputs in order and stable while stalled, mode bits follow their own samples.
6. Reset: assert rst low with 3 samples in flight -> out_valid=0, p=0, ovf=0 immediately (asynchronously); after release, no stale out_valid; next input emerges with latency 3.
